// File: rtl/cordic_fixedpoint_input_phase_sequencer.sv
// Walks the phase ROM 0..NUM_VECTORS-1, hiding its 1-cycle read latency, and hands each angle to the
// CORDIC core over valid/ready. Define CORDIC_SEQ_LOOP_EN to let a held iStart restart passes back-to-back.
module cordic_fixedpoint_input_phase_sequencer #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 24,
  parameter int NUM_VECTORS = 32
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  output logic [ADDR_W-1:0] oAddr_phase,
  input  logic [DATA_W-1:0] iPhase_rom,
  output logic [DATA_W-1:0] oPhase,
  output logic              oValid,
  input  logic              iReady,
  output logic              oBusy,
  output logic              oDone,
  output logic [ADDR_W:0]   oCount
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] index, index_nxt;
  logic              hs, last, restart;

  always_comb begin
    hs   = (state == S_VALID) && iReady;
    last = (index == ADDR_W'(NUM_VECTORS - 1));
`ifdef CORDIC_SEQ_LOOP_EN
    restart = hs && last && iStart;
`else
    restart = 1'b0;
`endif
  end

  always_ff @(posedge iClk) begin
    if (iRst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    index_nxt = index;
    case (state)
      S_IDLE:  if (iStart) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_VALID;
      S_VALID: begin
        if (hs) begin
          if (last) begin
            index_nxt = '0;
            state_nxt = restart ? S_FETCH : S_DONE;
          end else begin
            index_nxt = index + ADDR_W'(1);
            state_nxt = S_FETCH;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The ROM registers its address, so it is fed the next index during the handshake
  // cycle; that way the data for the new index is already there throughout FETCH.
  always_comb begin
    oAddr_phase = index_nxt;
    oValid      = (state == S_VALID);
    oBusy       = (state == S_FETCH) || (state == S_VALID);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      index  <= '0;
      oPhase <= '0;
      oCount <= '0;
      oDone  <= 1'b0;
    end else begin
      index <= index_nxt;
      oDone <= hs && last;
      if (state == S_FETCH) oPhase <= iPhase_rom;
      if (((state == S_IDLE) && iStart) || restart) oCount <= '0;
      else if (hs)                                 oCount <= oCount + CNT_W'(1);
    end
  end

endmodule
